// File: rtl/float_addsub_arb.sv
// Round-robin front end sharing one fixed-latency float add/sub pipeline among NREQ requesters.
// Results go back through per-requester FIFOs; credits admit an op only if its result has a slot.
module float_addsub_arb #(
  parameter int NREQ  = 4,
  parameter int LAT   = 7,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*32-1:0]   rsp_data,
  output logic [31:0]          fa_v1,
  output logic [31:0]          fa_v2,
  output logic                 fa_op,
  input  logic [31:0]          fa_vres,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] credit_q [NREQ];
  logic [CW-1:0] credit_d [NREQ];
  logic [CW-1:0] cnt_q    [NREQ];
  logic [CW-1:0] cnt_d    [NREQ];
  logic [PW-1:0] wptr_q   [NREQ];
  logic [PW-1:0] wptr_d   [NREQ];
  logic [PW-1:0] rptr_q   [NREQ];
  logic [PW-1:0] rptr_d   [NREQ];
  logic [31:0]   mem_q    [NREQ][DEPTH];

  // LAT stages so the id at the last stage lines up with fa_vres for the op issued LAT cycles earlier
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]  tag_id_q [LAT];
  logic [IW-1:0]  tag_id_d [LAT];

  logic          gnt_vld;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] idx;
  logic [NREQ-1:0] push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_vld && !rst && req_valid[idx] && credit_q[idx] != '0) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    fa_v1     = '0;
    fa_v2     = '0;
    fa_op     = 1'b0;
    if (gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
      fa_v1 = req_a[32*gnt_id +: 32];
      fa_v2 = req_b[32*gnt_id +: 32];
      fa_op = req_op[gnt_id];
    end
    rr_ptr_d = gnt_vld ? gnt_id : rr_ptr_q;
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = gnt_vld;
    tag_id_d[0]  = gnt_id;
    for (int k = 1; k < LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (cnt_q[i] != '0);
      push[i]      = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == IW'(i));
      pop[i]       = rsp_valid[i] && rsp_ready[i];
      cnt_d[i]     = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      credit_d[i]  = credit_q[i] - CW'(req_ready[i]) + CW'(pop[i]);
      wptr_d[i]    = push[i] ? ptr_inc(wptr_q[i]) : wptr_q[i];
      rptr_d[i]    = pop[i]  ? ptr_inc(rptr_q[i]) : rptr_q[i];
      if (rsp_valid[i])
        rsp_data[32*i +: 32] = mem_q[i][rptr_q[i]];
    end
  end

  assign busy = (|tag_vld_q) | (|rsp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= IW'(NREQ - 1);
      tag_vld_q <= '0;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
      for (int i = 0; i < NREQ; i++) begin
        credit_q[i] <= CW'(DEPTH);
        cnt_q[i]    <= '0;
        wptr_q[i]   <= '0;
        rptr_q[i]   <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int k = 0; k < LAT; k++) tag_id_q[k] <= tag_id_d[k];
      for (int i = 0; i < NREQ; i++) begin
        credit_q[i] <= credit_d[i];
        cnt_q[i]    <= cnt_d[i];
        wptr_q[i]   <= wptr_d[i];
        rptr_q[i]   <= rptr_d[i];
      end
    end
  end

  // Storage only; emptiness is tracked by cnt_q so the array needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (push[i]) mem_q[i][wptr_q[i]] <= fa_vres;
  end

endmodule

// File: tb/tb_float_addsub_arb.sv
// Bench for float_addsub_arb: behavioural adder stub plus a queue-based scheduler model.
module tb_float_addsub_arb;
  localparam int NREQ = 4, LAT = 7, DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [NREQ*32-1:0] req_a, req_b, rsp_data;
  logic [31:0]        fa_v1, fa_v2, fa_vres;
  logic               fa_op, busy;

  float_addsub_arb #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .fa_v1(fa_v1), .fa_v2(fa_v2),
    .fa_op(fa_op), .fa_vres(fa_vres), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i2f(input int v);
    logic s; int m; int p;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    for (int k = 0; k < 31; k++) if ((m >> k) != 0) p = k;
    return {s, 8'(127 + p), 23'((m << (23 - p)) & 32'h7FFFFF)};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) apipe[k] <= apipe[k-1];
    apipe[0] <= r2f(fa_op ? f2r(fa_v1) - f2r(fa_v2) : f2r(fa_v1) + f2r(fa_v2));
  end
  assign fa_vres = apipe[LAT-1];

  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int t; logic [31:0] res; } ent_t;
  ent_t mq [NREQ][$];
  int   mptr, cyc;
  int   gcount [NREQ];
  int   ai [NREQ], bi [NREQ];
  logic opi [NREQ];

  task automatic set_req(input int i, input int a, input int b, input logic op);
    ai[i] = a; bi[i] = b; opi[i] = op;
    req_a[32*i +: 32] = i2f(a);
    req_b[32*i +: 32] = i2f(b);
    req_op[i] = op;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++)
      set_req(i, int'($urandom_range(0, 100000)), int'($urandom_range(0, 100000)), 1'($urandom_range(0, 1)));
  endtask

  // Compare one cycle of outputs against the model, then advance the model across the edge
  task automatic step();
    int g, idx;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    logic exp_busy;
    logic [31:0] d;
    @(negedge clk);
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (g < 0 && req_valid[idx] && mq[idx].size() < DEPTH) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("fa_v1", fa_v1, (g >= 0) ? i2f(ai[g]) : 32'h0);
    check("fa_v2", fa_v2, (g >= 0) ? i2f(bi[g]) : 32'h0);
    check("fa_op", 32'(fa_op), (g >= 0) ? 32'(opi[g]) : 32'h0);
    exp_busy = 1'b0;
    exp_rv   = '0;
    for (int i = 0; i < NREQ; i++) begin
      exp_rv[i] = (mq[i].size() > 0) && (mq[i][0].t + LAT + 1 <= cyc);
      d = exp_rv[i] ? mq[i][0].res : 32'h0;
      check("rsp_data", rsp_data[32*i +: 32], d);
      foreach (mq[i][j]) if (mq[i][j].t < cyc) exp_busy = 1'b1;
      check("credit", 32'(dut.credit_q[i]), 32'(DEPTH - mq[i].size()));
    end
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(exp_busy));
    for (int i = 0; i < NREQ; i++)
      if (exp_rv[i] && rsp_ready[i]) void'(mq[i].pop_front());
    if (g >= 0) begin
      mq[g].push_back('{t: cyc, res: i2f(opi[g] ? ai[g] - bi[g] : ai[g] + bi[g])});
      mptr = g;
      gcount[g]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_rsp(input int i);
    for (int n = 0; n < 40; n++) begin
      if (rsp_valid[i]) break;
      step();
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    for (int n = 0; n < 200; n++) begin
      if (!busy) break;
      step();
    end
    check("drain_busy", 32'(busy), 32'h0);
  endtask

  int c0, g1;

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
    for (int i = 0; i < NREQ; i++) begin set_req(i, 0, 0, 1'b0); gcount[i] = 0; end
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fa_v1", fa_v1, 32'h0);
    check("rst_rsp_data", rsp_data[31:0], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0; mptr = NREQ - 1;

    // Single add on requester 0
    rsp_ready = '1;
    set_req(0, 1, 2, 1'b0);
    req_valid = 4'b0001;
    #1;
    check("add_ready", 32'(req_ready), 32'h1);
    check("add_v1", fa_v1, 32'h3F800000);
    check("add_v2", fa_v2, 32'h40000000);
    c0 = cyc;
    step();
    req_valid = '0;
    wait_rsp(0);
    check("add_latency", 32'(cyc - c0), 32'(LAT + 1));
    check("add_data", rsp_data[31:0], 32'h40400000);
    step();
    check("add_busy_after_pop", 32'(busy), 32'h0);

    // Subtract on requester 2
    set_req(2, 3, 1, 1'b1);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    wait_rsp(2);
    check("sub_data", rsp_data[95:64], 32'h40000000);
    check("sub_others", 32'(rsp_valid & 4'b1011), 32'h0);
    drain();

    // Round-robin with all requesters active
    for (int i = 0; i < NREQ; i++) gcount[i] = 0;
    req_valid = '1; rsp_ready = '1;
    for (int n = 0; n < 24; n++) begin rand_ops(); step(); end
    for (int i = 0; i < NREQ; i++) check("rr_share", 32'(gcount[i]), 32'd6);
    drain();

    // Backpressure on requester 1
    g1 = gcount[1];
    req_valid = '1; rsp_ready = 4'b1101;
    for (int n = 0; n < 48; n++) begin rand_ops(); step(); end
    check("bp_grants", 32'(gcount[1] - g1), 32'(DEPTH));
    rsp_ready = '1;
    for (int n = 0; n < 30; n++) begin rand_ops(); step(); end
    drain();

    // Credit at 1: pop and new grant in the same cycle
    rsp_ready = 4'b0111; req_valid = 4'b1000;
    for (int n = 0; n < DEPTH - 1; n++) begin rand_ops(); step(); end
    req_valid = '0;
    for (int n = 0; n < LAT + 2; n++) step();
    check("bnd_credit_pre", 32'(dut.credit_q[3]), 32'h1);
    rsp_ready = '1; req_valid = 4'b1000; rand_ops();
    #1;
    check("bnd_ready", 32'(req_ready), 32'h8);
    step();
    check("bnd_credit_post", 32'(dut.credit_q[3]), 32'h1);
    drain();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = NREQ'($urandom);
      rand_ops();
      step();
    end
    drain();

    // Reset with ops in flight
    req_valid = 4'b0111;
    for (int n = 0; n < 3; n++) begin rand_ops(); step(); end
    req_valid = 4'b0001;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_fa_v1", fa_v1, 32'h0);
    req_valid = '0;
    #1 rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      mq[i].delete();
      check("mid_rst_credit", 32'(dut.credit_q[i]), 32'(DEPTH));
    end
    mptr = NREQ - 1;
    for (int n = 0; n < 2 * LAT; n++) step();
    set_req(0, 5, 7, 1'b0);
    req_valid = 4'b0001;
    c0 = cyc;
    step();
    req_valid = '0;
    wait_rsp(0);
    check("post_rst_latency", 32'(cyc - c0), 32'(LAT + 1));
    check("post_rst_data", rsp_data[31:0], 32'h41400000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
